// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: ALU op codes, memory op codes,
// FSM state encoding and small op-classification helpers.
package mem_access_pkg;

  // Existing ALU op codes.
  localparam logic [7:0] OpNop = 8'b0000_0000;
  localparam logic [7:0] OpOr  = 8'b0010_0101;
  localparam logic [7:0] OpAdd = 8'b0010_0000;

  // Memory op codes.
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_byte_op(logic [7:0] op);
    return (op == OpLb) || (op == OpLbu) || (op == OpSb);
  endfunction

  function automatic logic is_half_op(logic [7:0] op);
    return (op == OpLh) || (op == OpLhu) || (op == OpSh);
  endfunction

  function automatic logic is_word_op(logic [7:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

  function automatic logic is_mem_op(logic [7:0] op);
    return is_byte_op(op) || is_half_op(op) || is_word_op(op);
  endfunction

  function automatic logic is_misaligned(logic [7:0] op, logic [1:0] off);
    logic res;
    res = 1'b0;
    if (is_half_op(op)) res = off[0];
    else if (is_word_op(op)) res = (off != 2'b00);
    return res;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it according to the load op. Purely combinational.
//   aluop_i  load op (LB/LBU/LH/LHU/LW)
//   off_i    byte offset within the word (addr[1:0])
//   rdata_i  raw little-endian word from the bus
//   data_o   aligned, extended load result
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (aluop_i)
      OpLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   data_o = {24'b0, byte_sel};
      OpLh:    data_o = {{16{half_sel[15]}}, half_sel};
      OpLhu:   data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory ops pass straight through to WB;
// loads/stores run a request/ack bus handshake (IDLE -> WAIT -> DONE) while
// stalling the pipeline, with misalignment detection and a bus timeout.
//   clk, rst                  clock, synchronous active-high reset
//   aluop_i, mem_addr_i,
//   reg2_i, is_load_i         op, byte address, store data, load marker
//   wd_i, wreg_i, wdata_i     writeback target/enable/ALU result from EX
//   wd_o, wreg_o, wdata_o     writeback target/enable/data to WB
//   stall_req_o               hold the stage inputs
//   misalign_o, bus_err_o     single-cycle exception flags
//   ram_*                     word-addressed bus with byte-lane select
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        is_load_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic [7:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            err_q, err_d;

  logic            mem_op, misaligned, timeout_hit;
  logic [3:0]      lane_sel;
  logic [31:0]     lane_wdata, load_data;

  assign mem_op     = is_mem_op(aluop_i);
  assign misaligned = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);

  // Byte-lane mask and lane-replicated store data for the incoming op.
  always_comb begin
    lane_sel   = 4'b1111;
    lane_wdata = reg2_i;
    if (is_byte_op(aluop_i)) begin
      lane_sel   = 4'b0001 << mem_addr_i[1:0];
      lane_wdata = {4{reg2_i[7:0]}};
    end else if (is_half_op(aluop_i)) begin
      lane_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{reg2_i[15:0]}};
    end
  end

  mem_access_load_align u_load_align (
    .aluop_i (op_q),
    .off_i   (off_q),
    .rdata_i (rdata_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    op_d        = op_q;
    off_d       = off_q;
    err_d       = err_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && !misaligned) begin
          state_d = StWait;
          cnt_d   = '0;
          addr_d  = {mem_addr_i[31:2], 2'b00};
          wdat_d  = lane_wdata;
          sel_d   = lane_sel;
          we_d    = !is_load_i;
          op_d    = aluop_i;
          off_d   = mem_addr_i[1:0];
          err_d   = 1'b0;
        end
      end
      StWait: begin
        // An ack in the timeout cycle takes priority over the abort.
        if (ram_ack_i) begin
          rdata_d = ram_rdata_i;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          err_d       = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      op_q    <= OpNop;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      op_q    <= op_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, including the cycle in
  // which reset lands on a WAIT state.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_sel_o   = '0;
    ram_wdata_o = '0;
    if (!rst) begin
      wd_o = wd_i;
      unique case (state_q)
        StIdle: begin
          wdata_o = wdata_i;
          if (!mem_op)         wreg_o      = wreg_i;
          else if (misaligned) misalign_o  = 1'b1;
          else                 stall_req_o = 1'b1;
        end
        StWait: begin
          wdata_o     = wdata_i;
          stall_req_o = 1'b1;
          bus_err_o   = timeout_hit;
          ram_req_o   = 1'b1;
          ram_we_o    = we_q;
          ram_addr_o  = addr_q;
          ram_sel_o   = sel_q;
          ram_wdata_o = wdat_q;
        end
        StDone: begin
          wdata_o = we_q ? wdata_i : load_data;
          wreg_o  = !we_q && !err_q && wreg_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int unsigned To = 4;

  logic        clk, rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, ram_rdata_i;
  logic        is_load_i, wreg_i, ram_ack_i;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_o, stall_req_o, misalign_o, bus_err_o, ram_req_o, ram_we_o;
  logic [31:0] wdata_o, ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;

  mem_access #(.TIMEOUT(To)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .is_load_i   (is_load_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .ram_req_o   (ram_req_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_sel_o   (ram_sel_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_ack_i   (ram_ack_i),
    .ram_rdata_i (ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic        is_load;
    logic [31:0] wdata_i;
    logic [31:0] rdata;
    int          ack_at;     // WAIT cycle (1-based) carrying the ack; 0 = never
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] exp_wdata;
    logic        chk_wdata;
    logic        exp_wreg;
    int          stalls;
    logic        mis;
    logic        berr;
  } vec_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t        e;
    int          stalls, reqs, mis, berr, err_cyc, exp_reqs;
    logic        done, unstable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic        s_we;
    stalls = 0; reqs = 0; mis = 0; berr = 0; err_cyc = 0;
    done = 1'b0; unstable = 1'b0;
    s_addr = '0; s_wdata = '0; s_sel = '0; s_we = 1'b0;
    @(posedge clk); #1;
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; is_load_i = v.is_load;
    wd_i = 5'(idx + 1); wreg_i = 1'b1; wdata_i = v.wdata_i;
    ram_ack_i = 1'b0; ram_rdata_i = ~v.rdata;
    sb_q.push_back('{wd: 5'(idx + 1), wreg: v.exp_wreg, wdata: v.exp_wdata, chk: v.chk_wdata});
    for (int cyc = 0; cyc < 16 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        ram_ack_i   = (cyc == v.ack_at);
        ram_rdata_i = ram_ack_i ? v.rdata : ~v.rdata;
      end
      @(negedge clk);
      if (misalign_o) mis++;
      if (bus_err_o) begin berr++; err_cyc = cyc; end
      if (ram_req_o) begin
        if (reqs == 0) begin
          s_addr = ram_addr_o; s_sel = ram_sel_o; s_we = ram_we_o; s_wdata = ram_wdata_o;
          check("bus_addr", idx, ram_addr_o, {v.addr[31:2], 2'b00});
          check("bus_sel", idx, 32'(ram_sel_o), 32'(v.sel));
          check("bus_we", idx, 32'(ram_we_o), 32'(!v.is_load));
          if (!v.is_load) check("bus_wdata", idx, ram_wdata_o, v.bwdata);
        end else if (ram_addr_o !== s_addr || ram_sel_o !== s_sel || ram_we_o !== s_we ||
                     ram_wdata_o !== s_wdata) begin
          unstable = 1'b1;
        end
        reqs++;
      end
      if (stall_req_o) stalls++;
      else begin
        done = 1'b1;
        e = sb_q.pop_front();
        check("wd_o", idx, 32'(wd_o), 32'(e.wd));
        check("wreg_o", idx, 32'(wreg_o), 32'(e.wreg));
        if (e.chk) check("wdata_o", idx, wdata_o, e.wdata);
        aluop_i = OpNop; wreg_i = 1'b0; ram_ack_i = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL no_completion (vec %0d): got stall after %0d cycles expected release", idx,
               stalls);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      aluop_i = OpNop; wreg_i = 1'b0; ram_ack_i = 1'b0;
    end
    exp_reqs = (v.stalls > 0) ? v.stalls - 1 : 0;
    check("stall_cycles", idx, stalls, v.stalls);
    check("req_cycles", idx, reqs, exp_reqs);
    check("misalign", idx, mis, 32'(v.mis));
    check("bus_err", idx, berr, 32'(v.berr));
    if (v.berr) check("bus_err_cycle", idx, err_cyc, To);
    if (reqs > 1) check("bus_stable", idx, 32'(unstable), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int bad;
    //        op     addr          reg2          ld    wdata_i       rdata         ack sel
    //        bwdata        exp_wdata     chk   wreg  stl mis   berr
    vecs[0]  = '{OpAdd, 32'h0,     32'h0,        1'b0, 32'h12345678, 32'h0,        0, 4'b0000,
                 32'h0,        32'h12345678, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    vecs[1]  = '{OpLw,  32'h100,   32'h0,        1'b1, 32'h1111,     32'hDEADBEEF, 2, 4'b1111,
                 32'h0,        32'hDEADBEEF, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    vecs[2]  = '{OpLb,  32'h103,   32'h0,        1'b1, 32'h2222,     32'h80112233, 1, 4'b1000,
                 32'h0,        32'hFFFFFF80, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[3]  = '{OpLbu, 32'h103,   32'h0,        1'b1, 32'h3333,     32'h80112233, 1, 4'b1000,
                 32'h0,        32'h00000080, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[4]  = '{OpLh,  32'h102,   32'h0,        1'b1, 32'h4444,     32'h80112233, 1, 4'b1100,
                 32'h0,        32'hFFFF8011, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[5]  = '{OpLhu, 32'h100,   32'h0,        1'b1, 32'h5555,     32'h80112233, 1, 4'b0011,
                 32'h0,        32'h00002233, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[6]  = '{OpSh,  32'h202,   32'h1234ABCD, 1'b0, 32'h6666,     32'h0,        1, 4'b1100,
                 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[7]  = '{OpSb,  32'h301,   32'h000000A5, 1'b0, 32'h7777,     32'h0,        1, 4'b0010,
                 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[8]  = '{OpSw,  32'h400,   32'hCAFEF00D, 1'b0, 32'h8888,     32'h0,        3, 4'b1111,
                 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 4, 1'b0, 1'b0};
    vecs[9]  = '{OpLw,  32'h101,   32'h0,        1'b1, 32'h9999,     32'h0,        0, 4'b0000,
                 32'h0,        32'h0,        1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[10] = '{OpSh,  32'h203,   32'h1234,     1'b0, 32'hAAAA,     32'h0,        0, 4'b0000,
                 32'h0,        32'h0,        1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[11] = '{OpSw,  32'h500,   32'h55,       1'b0, 32'hBBBB,     32'h0,        0, 4'b1111,
                 32'h55,       32'h0,        1'b0, 1'b0, 5, 1'b0, 1'b1};
    vecs[12] = '{OpSw,  32'h500,   32'h66,       1'b0, 32'hCCCC,     32'h0,        4, 4'b1111,
                 32'h66,       32'h0,        1'b0, 1'b0, 5, 1'b0, 1'b0};
    vecs[13] = '{OpLw,  32'h600,   32'h0,        1'b1, 32'hDDDD,     32'h0,        0, 4'b1111,
                 32'h0,        32'h0,        1'b0, 1'b0, 5, 1'b0, 1'b1};
    vecs[14] = '{OpLb,  32'h100,   32'h0,        1'b1, 32'hEEEE,     32'h0000007F, 1, 4'b0001,
                 32'h0,        32'h0000007F, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[15] = '{OpLhu, 32'h102,   32'h0,        1'b1, 32'hFFFF,     32'hFFFF0000, 1, 4'b1100,
                 32'h0,        32'h0000FFFF, 1'b1, 1'b1, 2, 1'b0, 1'b0};

    // Reset: outputs held low even with a live pass-through op on the inputs.
    rst = 1'b1; aluop_i = OpAdd; mem_addr_i = '0; reg2_i = '0; is_load_i = 1'b0;
    wd_i = 5'h1f; wreg_i = 1'b1; wdata_i = 32'hFFFFFFFF; ram_ack_i = 1'b0; ram_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wreg", 0, 32'(wreg_o), 32'd0);
    check("rst_wdata", 0, wdata_o, 32'd0);
    check("rst_wd", 0, 32'(wd_o), 32'd0);
    check("rst_stall", 0, 32'(stall_req_o), 32'd0);
    check("rst_req", 0, 32'(ram_req_o), 32'd0);
    rst = 1'b0; aluop_i = OpNop; wreg_i = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset landing in WAIT abandons the request.
    @(posedge clk); #1;
    aluop_i = OpLw; mem_addr_i = 32'h700; is_load_i = 1'b1; wreg_i = 1'b1; ram_ack_i = 1'b0;
    @(negedge clk);
    check("rw_idle_stall", 100, 32'(stall_req_o), 32'd1);
    @(negedge clk);
    check("rw_wait_req", 100, 32'(ram_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rw_gate_req", 100, 32'(ram_req_o), 32'd0);
    check("rw_gate_stall", 100, 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = OpAdd; is_load_i = 1'b0; wreg_i = 1'b1; wdata_i = 32'h0BADF00D;
    @(negedge clk);
    check("rw_after_req", 100, 32'(ram_req_o), 32'd0);
    check("rw_after_stall", 100, 32'(stall_req_o), 32'd0);
    check("rw_after_wreg", 100, 32'(wreg_o), 32'd1);
    check("rw_after_wdata", 100, wdata_o, 32'h0BADF00D);
    aluop_i = OpNop; wreg_i = 1'b0;

    // Ack outside WAIT must do nothing.
    @(posedge clk); #1;
    aluop_i = OpAdd; wreg_i = 1'b1; wdata_i = 32'h77; ram_ack_i = 1'b1; ram_rdata_i = '1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (stall_req_o || ram_req_o || bus_err_o || wdata_o !== 32'h77) bad++;
    end
    check("ack_idle", 101, bad, 0);
    ram_ack_i = 1'b0; aluop_i = OpNop; wreg_i = 1'b0;

    // Normal traffic after the abandoned transaction.
    run_vec(1, vecs[1]);
    check("sb_empty", 102, sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of cycles waited for ram_ack_i before a bus request is aborted.
REQ-002 clk  input  1  is the system clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  is the reset, synchronous, active-high.
REQ-004 aluop_i  input  8  is the operation from the execute stage: LB, LH, LW, LBU, LHU, SB, SH, SW or a non-memory op.
REQ-005 mem_addr_i  input  32 is the effective byte address; reg2_i  input  32 is the store data.
REQ-006 is_load_i  input  1 marks a load; wd_i  input  5, wreg_i  input  1 and wdata_i  input  32 are the writeback target, enable and ALU result.
REQ-007 wd_o  output  5, wreg_o  output  1 and wdata_o  output  32 are the writeback target, enable and data to the WB stage.
REQ-008 stall_req_o  output  1 requests that the pipeline hold the stage inputs.
REQ-009 misalign_o  output  1 and bus_err_o  output  1 are single-cycle exception flags.
REQ-010 Bus outputs: ram_req_o 1, ram_we_o 1, ram_addr_o 32 (word-aligned), ram_sel_o 4 (byte-lane mask), ram_wdata_o 32.
REQ-011 Bus inputs: ram_ack_i 1 and ram_rdata_i 32.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-013 For a non-memory aluop_i in IDLE, wd_o, wreg_o and wdata_o SHALL equal wd_i, wreg_i and wdata_i combinationally, with stall_req_o=0 and no bus activity.
REQ-014 For an aligned memory op in IDLE, stall_req_o SHALL be 1 and the next state SHALL be WAIT, with ram_addr_o={mem_addr_i[31:2],2'b00}, ram_we_o=!is_load_i and ram_sel_o and ram_wdata_o registered.
REQ-015 ram_req_o SHALL be 1 only in WAIT, with all bus outputs stable until the cycle in which ram_ack_i=1 is sampled.
REQ-016 In WAIT, stall_req_o SHALL be 1; when ram_ack_i=1, ram_rdata_i SHALL be captured and the next state SHALL be DONE.
REQ-017 In DONE, stall_req_o SHALL be 0, wdata_o SHALL be the aligned load data for loads, wreg_o SHALL equal wreg_i for loads and 0 for stores, and the next state SHALL be IDLE.
REQ-018 Minimum latency SHALL be 3 cycles (IDLE, WAIT, DONE) when ack arrives in the first WAIT cycle.
REQ-019 Store lanes SHALL be: SB ram_sel_o=1<<addr[1:0] with the byte replicated ×4; SH ram_sel_o=addr[1]?4'b1100:4'b0011 with the halfword replicated ×2; SW ram_sel_o=4'b1111.
REQ-020 Load extraction SHALL select the byte or halfword by addr[1:0]; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-021 LH, LHU or SH with addr[0]=1, or LW or SW with addr[1:0]≠0, SHALL raise misalign_o=1 for one cycle in IDLE, with no bus request, wreg_o=0 and stall_req_o=0.
REQ-022 A cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT without ack, the request SHALL be dropped, bus_err_o SHALL pulse for one cycle, and the FSM SHALL go to DONE with wreg_o=0.
REQ-023 An ack arriving in the same cycle as the timeout SHALL win, completing normally with no bus_err_o.
REQ-024 ram_ack_i SHALL be ignored outside WAIT.

Reset
REQ-025 While rst=1 the block SHALL enter IDLE, clear the counter and capture register, and drive all outputs to 0, including ram_req_o, stall_req_o and wreg_o.
REQ-026 Reset asserted in WAIT SHALL abandon the transaction immediately, with ram_req_o=0 on the following cycle.

Structure
REQ-027 Memory aluop encodings and the FSM state encodings SHALL reside in the shared defines file alongside the existing ALU op codes.
REQ-028 Load byte/halfword selection and extension SHALL be a combinational sub-module, load_align.

Verification
REQ-029 LW at addr 0x100 with ack after 2 WAIT cycles and rdata 0xDEADBEEF -> stall for 3 cycles, ram_sel_o=1111, wdata_o=0xDEADBEEF, wreg_o=1 in DONE.
REQ-030 LB at addr 0x103 with rdata 0x80112233 -> ram_sel_o=1000, wdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-031 SH at addr 0x202 with reg2_i=0x1234ABCD -> ram_addr_o=0x200, ram_sel_o=1100, ram_wdata_o=0xABCDABCD, ram_we_o=1, wreg_o=0.
REQ-032 LW at addr 0x101 -> misalign_o pulses, ram_req_o stays 0, stall_req_o=0.
REQ-033 SW with TIMEOUT=4 and no ack -> bus_err_o pulses on the 4th WAIT cycle, then DONE, then IDLE; a variant with ack on that same cycle -> no bus_err_o.
REQ-034 rst asserted during WAIT -> the next cycle shows ram_req_o=0, stall_req_o=0 and state IDLE.
